// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM and counting-mode types for the PWM bank.
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  typedef enum logic {EDGE, CENTER} mode_t;
endpackage

// File: rtl/pwm_cmp.sv
// pwm_cmp: one channel; holds the committed duty and registers cnt < duty.
module pwm_cmp #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DWIDTH-1:0] duty,
  input  logic [DWIDTH-1:0] cnt,
  output logic              out
);
  logic [DWIDTH-1:0] active;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      active <= '0;
      out <= 1'b0;
    end else begin
      if (load) active <= duty;
      out <= en && (cnt < active);
    end
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: STAGE-channel PWM with shared counter, run/stop FSM and a
// double-buffered duty frame committed only at period boundaries.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int STAGE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              center,
  input  logic              data_valid,
  input  logic [DWIDTH-1:0] data,
  input  logic              hsync,
  output logic [STAGE-1:0]  out,
  output logic              period_end,
  output logic              load_done,
  output logic              busy
);
  localparam int PW = STAGE > 1 ? $clog2(STAGE) : 1;
  localparam logic [DWIDTH-1:0] TOP = {{(DWIDTH-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0] LAST = PW'(STAGE - 1);
  state_t state, state_nx;
  mode_t mode;
  logic [DWIDTH-1:0] cnt;
  logic down;
  logic [PW-1:0] ptr;
  logic pending;
  logic [DWIDTH-1:0] shadow [STAGE];
  logic launch, commit, frame_done;
  always_comb
    state_nx = (state == IDLE) ? (start ? RUN : IDLE)
             : start ? RUN
             : (state == STOPPING && period_end) ? IDLE : STOPPING;
  assign busy       = state != IDLE;
  assign period_end = busy && ((mode == CENTER) ? (down && cnt == '0) : (cnt == TOP));
  assign launch     = state == IDLE && start;
  // A frame finishing this very cycle is not pending yet, so it waits a period.
  assign commit     = pending && (launch || (period_end && ptr == '0));
  assign frame_done = data_valid && !hsync && ptr == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      mode <= EDGE;
      cnt <= '0;
      down <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) mode <= mode_t'(center);
      if (!busy || period_end) begin
        cnt <= '0;
        down <= 1'b0;
      end else if (mode == EDGE) cnt <= cnt + DWIDTH'(1);
      else if (!down && cnt == TOP) down <= 1'b1;
      else cnt <= down ? cnt - DWIDTH'(1) : cnt + DWIDTH'(1);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= '0;
      pending <= 1'b0;
      load_done <= 1'b0;
      for (int i = 0; i < STAGE; i++) shadow[i] <= '0;
    end else begin
      load_done <= frame_done;
      pending <= frame_done || (pending && !commit);
      if (data_valid) shadow[hsync ? '0 : ptr] <= data;
      ptr <= hsync ? PW'(data_valid)
           : !data_valid ? ptr
           : (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  for (genvar i = 0; i < STAGE; i++) begin : g_ch
    pwm_cmp #(.DWIDTH(DWIDTH)) u_cmp (
      .clk (clk),
      .rst (rst),
      .en  (busy),
      .load(commit),
      .duty(shadow[i]),
      .cnt (cnt),
      .out (out[i])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed self-checking bench for pwm_bank at DWIDTH=4, STAGE=4.
module tb_pwm_bank;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, center = 1'b0, data_valid = 1'b0, hsync = 1'b0;
  logic [3:0] data = '0;
  logic [3:0] out;
  logic period_end, load_done, busy;
  int checks = 0, errors = 0, ld_cnt = 0, pe_cnt = 0;
  int hi [4];
  logic [31:0] pat;

  always #5 clk = ~clk;

  pwm_bank #(.DWIDTH(4), .STAGE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .center    (center),
    .data_valid(data_valid),
    .data      (data),
    .hsync     (hsync),
    .out       (out),
    .period_end(period_end),
    .load_done (load_done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ld_cnt += int'(load_done);
  endtask

  task automatic send(input logic [3:0] d, input logic hs);
    data = d;
    data_valid = 1'b1;
    hsync = hs;
    step();
    data_valid = 1'b0;
    hsync = 1'b0;
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
  endtask

  task automatic wait_pe(input string tag);
    for (int i = 0; i < 100; i++) begin
      step();
      if (period_end) return;
    end
    check({tag, "_timeout"}, 32'(period_end), 1);
  endtask

  // Called on a period_end sample; skips the lag cycle, then samples one period.
  task automatic measure(input int len);
    pe_cnt = 0;
    pat = '0;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    step();
    for (int k = 0; k < len; k++) begin
      step();
      pe_cnt += int'(period_end);
      pat[k] = out[0];
      for (int c = 0; c < 4; c++) hi[c] += int'(out[c]);
    end
  endtask

  task automatic check_hi(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_ch0"}, hi[0], a);
    check({tag, "_ch1"}, hi[1], b);
    check({tag, "_ch2"}, hi[2], c);
    check({tag, "_ch3"}, hi[3], d);
  endtask

  initial begin
    #12;
    check("rst_out", 32'(out), 0);
    check("rst_flags", 32'({period_end, load_done, busy}), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("idle_busy", 32'(busy), 0);
    // edge mode
    frame(4'd0, 4'd5, 4'd15, 4'd8);
    check("edge_ld", 32'(load_done), 1);
    start = 1'b1;
    step();
    check("run_busy", 32'(busy), 1);
    step();
    check("first_out", 32'(out), 32'b1110);
    wait_pe("edge");
    measure(15);
    check_hi("edge", 0, 5, 15, 8);
    check("edge_pe", pe_cnt, 1);
    // stop at cnt=6
    wait_pe("stop");
    repeat (7) step();
    start = 1'b0;
    step();
    check("stop_busy", 32'(busy), 1);
    wait_pe("stop_end");
    check("stop_last", 32'(busy), 1);
    step();
    check("stop_idle", 32'(busy), 0);
    step();
    check("stop_out", 32'(out), 0);
    // stop then resume before period end
    start = 1'b1;
    step();
    wait_pe("resume");
    repeat (7) step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1;
    wait_pe("resume_end");
    check("resume_busy", 32'(busy), 1);
    measure(15);
    check("resume_ch1", hi[1], 5);
    check("resume_pe", pe_cnt, 1);
    // double buffer: frame completes mid-period
    wait_pe("dbuf");
    repeat (2) step();
    frame(4'd10, 4'd10, 4'd10, 4'd10);
    check("dbuf_ld", 32'(load_done), 1);
    check("dbuf_hold_a", 32'(out), 32'b1110);
    repeat (6) step();
    check("dbuf_hold_b", 32'(out), 32'b0100);
    wait_pe("dbuf_end");
    measure(15);
    check_hi("dbuf", 10, 10, 10, 10);
    // frame completing in the period_end cycle commits one period later
    repeat (11) step();
    send(4'd2, 1'b0);
    send(4'd2, 1'b0);
    send(4'd2, 1'b0);
    check("late_align", 32'(period_end), 1);
    send(4'd2, 1'b0);
    check("late_ld", 32'(load_done), 1);
    repeat (5) step();
    check("late_defer", 32'(out), 32'b1111);
    wait_pe("late");
    measure(15);
    check_hi("late", 2, 2, 2, 2);
    // hsync discards a partial frame
    ld_cnt = 0;
    send(4'd7, 1'b0);
    send(4'd7, 1'b0);
    hsync = 1'b1;
    step();
    hsync = 1'b0;
    frame(4'd3, 4'd3, 4'd3, 4'd3);
    step();
    check("hs_ld", ld_cnt, 1);
    wait_pe("hs");
    measure(15);
    check_hi("hs", 3, 3, 3, 3);
    // hsync together with data_valid
    ld_cnt = 0;
    send(4'd1, 1'b0);
    send(4'd6, 1'b1);
    send(4'd6, 1'b0);
    send(4'd6, 1'b0);
    send(4'd6, 1'b0);
    check("hs_dv_ld", ld_cnt, 1);
    wait_pe("hs_dv");
    measure(15);
    check_hi("hs_dv", 6, 6, 6, 6);
    // center mode, loaded while idle
    start = 1'b0;
    wait_pe("c_stop");
    step();
    check("c_idle", 32'(busy), 0);
    frame(4'd4, 4'd0, 4'd0, 4'd0);
    start = 1'b1;
    center = 1'b1;
    step();
    center = 1'b0;
    wait_pe("center");
    measure(30);
    check("center_hi", hi[0], 8);
    check("center_ch1", hi[1], 0);
    check("center_pat", pat, 32'h3C00000F);
    check("center_pe", pe_cnt, 1);
    // asynchronous reset with a pending frame
    wait_pe("rst");
    frame(4'd9, 4'd9, 4'd9, 4'd9);
    check("rst_pre_out", 32'(out), 32'b0001);
    check("rst_pre_ld", 32'(load_done), 1);
    #2;
    rst = 1'b0;
    start = 1'b0;
    #1;
    check("rst_async", 32'({out, period_end, load_done, busy}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check("rst_idle", 32'({out, busy}), 0);
    start = 1'b1;
    step();
    wait_pe("post_rst");
    measure(15);
    check_hi("post_rst", 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: duty and counter width; MAX = 2^DWIDTH-1.
REQ-002 SHALL have parameter STAGE, default 8: number of PWM channels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: level; high requests running, low requests stop.
REQ-006 SHALL have port center, input, 1 bit: mode; 0 = edge-aligned, 1 = center-aligned.
REQ-007 SHALL have port data_valid, input, 1 bit: qualifies data.
REQ-008 SHALL have port data, input, DWIDTH bits: duty word for the channel at the write pointer.
REQ-009 SHALL have port hsync, input, 1 bit: frame resync; clears the write pointer.
REQ-010 SHALL have port out, output, STAGE bits: registered PWM outputs, one bit per channel.
REQ-011 SHALL have port period_end, output, 1 bit: one-cycle pulse on the last cycle of each period.
REQ-012 SHALL have port load_done, output, 1 bit: one-cycle pulse when a complete frame of STAGE words is captured.
REQ-013 SHALL have port busy, output, 1 bit: high while the FSM is in RUN or STOPPING.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and STOPPING.
- IDLE->RUN when start=1.
- RUN->STOPPING when start=0.
- STOPPING->RUN when start=1 before period end.
- STOPPING->IDLE at the period end.
REQ-015 SHALL sample center on the IDLE->RUN transition only, and hold it until IDLE.
REQ-016 SHALL run the edge-mode counter 0,1,...,MAX-1, then wrap; the period is MAX cycles.
REQ-017 SHALL run the center-mode counter 0..MAX-1 up, then MAX-1..0 down; the period is 2*MAX cycles.
REQ-018 SHALL drive out[i] = (cnt < active[i]), registered, so out lags cnt by 1 cycle.
- duty 0 gives a constant low output.
- duty MAX gives a constant high output.
REQ-019 SHALL hold out at 0 and cnt at 0 in IDLE.
REQ-020 SHALL write each data_valid word to shadow[ptr], then increment ptr.
- When ptr reaches STAGE-1 it wraps to 0, pulses load_done and sets pending.
REQ-021 SHALL force ptr to 0 on hsync=1, discarding any partial frame.
- If hsync and data_valid are high in the same cycle, the word is written to shadow[0] and ptr becomes 1.
REQ-022 SHALL copy shadow to active and clear pending on the period_end cycle, provided pending=1 and ptr=0.
- Otherwise the commit is deferred to the next period end.
REQ-023 SHALL not commit, in the period_end cycle itself, a frame that completes in that same cycle; it commits at the following period end.
REQ-024 SHALL commit any pending frame on the IDLE->RUN transition, so the first period uses the new duty values.
REQ-025 SHALL let words arriving while pending=1 overwrite shadow; the commit takes the shadow contents at commit time.
REQ-026 SHALL drive busy from the registered state; period_end also pulses on the final period in STOPPING.

Reset
REQ-027 SHALL, on rst=0, immediately and asynchronously clear the following:
- state to IDLE;
- cnt, count direction, ptr and pending to 0;
- all shadow and active registers to 0;
- out, period_end, load_done and busy to 0.
REQ-028 SHALL, when rst is asserted mid-period, discard that period with no further pulses; on release the block stays in IDLE until start=1.

Structure
REQ-029 SHALL place the FSM state enum (IDLE/RUN/STOPPING) and the mode enum (EDGE/CENTER) in a shared package named pwm_pkg.
REQ-030 SHALL instantiate one sub-module, pwm_cmp, per channel: it holds active[i] and produces the registered compare output.
REQ-031 SHALL keep the counter, FSM, shadow array and write pointer in pwm_bank.

Verification
Benches run with DWIDTH=4 (MAX=15) and STAGE=4.
REQ-032 SHALL cover edge mode:
- Stimulus: load duties 0,5,15,8, then start=1.
- Response: per 15-cycle period, out[0] is never high, out[1] high 5 cycles, out[2] always high, out[3] high 8 cycles; period_end every 15 cycles.
REQ-033 SHALL cover center mode:
- Stimulus: duty 4 on channel 0.
- Response: out[0] high 8 cycles per 30-cycle period, symmetric about the period start; period_end every 30 cycles.
REQ-034 SHALL cover the double buffer:
- Stimulus: a new frame completes mid-period.
- Response: out changes only in the cycle after period_end.
- A frame completing in the period_end cycle takes effect one period later.
REQ-035 SHALL cover hsync:
- Stimulus: 2 words, then hsync, then 4 words 3,3,3,3.
- Response: a single load_done; all channels commit 3.
REQ-036 SHALL cover stop:
- Stimulus: drop start at cnt=6 (edge mode).
- Response: busy stays high to period_end; the period completes; then IDLE with out=0.
- Raising start again before the period end continues without a gap.
REQ-037 SHALL cover asynchronous reset:
- Stimulus: assert rst=0 mid-period with pending=1.
- Response: all outputs are 0 in the same cycle; after release and start, duties are 0 (the pending frame is lost).
